// File: rtl/disp_scan_ctrl_pkg.sv
// Shared display definitions for the 4-digit 7-segment path.
// Holds the digit-select one-hot codes, the bit positions inside the
// display-state word, and the default last animation frame index that the
// downstream decoder's letter tables are sized against.
package disp_scan_ctrl_pkg;

  // One-hot, active-high digit selects; bit n drives digit n.
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_D0   = 4'b0001;
  localparam logic [3:0] SEL_D1   = 4'b0010;
  localparam logic [3:0] SEL_D2   = 4'b0100;
  localparam logic [3:0] SEL_D3   = 4'b1000;

  // Bit positions inside DIS_CURRENT_STATE.
  localparam int DIS_LO = 0;  // message on digits 1:0
  localparam int DIS_HI = 1;  // message on digits 3:2

  // Animation runs frames 0..FRAME_LAST_DFLT; the decoder has one glyph set per frame.
  localparam int FRAME_LAST_DFLT = 6;

  // Digit pointer to its one-hot select.
  function automatic logic [3:0] sel_onehot(input logic [1:0] ptr);
    case (ptr)
      2'd0:    return SEL_D0;
      2'd1:    return SEL_D1;
      2'd2:    return SEL_D2;
      default: return SEL_D3;
    endcase
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Modulo-N counter with a single-cycle wrap indication.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   en_i    count enable
//   clr_i   synchronous clear to 0, wins over en_i
//   cnt_o   current count, 0..N-1
//   wrap_o  high in the cycle where an enabled count steps N-1 -> 0
module disp_prescaler #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap_o  = en_i & ~clr_i & at_last;
  assign cnt_o   = cnt_q;

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Rotates a one-hot digit select across the four BCD time digits, blanking
// the first BLANK_CYCLES of each slot, and in message mode substitutes an
// animation frame index for the digits of the active pair.
//   CLK                system clock
//   RESET              asynchronous active-low reset
//   DIGIT0..DIGIT3     BCD digits, DIGIT0 rightmost (minutes ones)
//   TOP_CURRENT_STATE  alarm/message state active
//   DIS_CURRENT_STATE  bit0 = message on digits 1:0, bit1 = on digits 3:2
//   COUNT              value to the 7-segment decoder (registered)
//   SA                 one-hot digit select, active-high (registered)
//   FRAME_TICK         one-cycle pulse as the frame index advances
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int FRAME_DIV    = 50,
  parameter int FRAME_LAST   = FRAME_LAST_DFLT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DIGIT0,
  input  logic [3:0] DIGIT1,
  input  logic [3:0] DIGIT2,
  input  logic [3:0] DIGIT3,
  input  logic       TOP_CURRENT_STATE,
  input  logic [1:0] DIS_CURRENT_STATE,
  output logic [3:0] COUNT,
  output logic [3:0] SA,
  output logic       FRAME_TICK
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [3:0]    FRAME_MAX = 4'(FRAME_LAST);

  logic [SW-1:0] scan_cnt;
  logic          scan_wrap;
  logic          digit_wrap;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    frm_q, frm_d;
  logic [3:0]    sa_q, sa_d;
  logic [3:0]    count_q, count_d;
  logic          tick_q, tick_d;
  logic          msg_lo, msg_hi, msg_act;
  logic          frame_wrap;
  logic          pane_msg;
  logic [3:0]    digit_val;
  // Position inside the current animation step; only its wrap is consumed.
  logic [FW-1:0] unused_frame_cnt;

  // Low pair wins when both message bits are set.
  assign msg_lo  = TOP_CURRENT_STATE & DIS_CURRENT_STATE[DIS_LO];
  assign msg_hi  = TOP_CURRENT_STATE & DIS_CURRENT_STATE[DIS_HI] & ~msg_lo;
  assign msg_act = msg_lo | msg_hi;

  assign digit_wrap = scan_wrap & (dig_q == 2'd3);

  disp_prescaler #(.N(SCAN_DIV)) u_scan_div (
    .clk    (CLK),
    .rst_n  (RESET),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .cnt_o  (scan_cnt),
    .wrap_o (scan_wrap)
  );

  // Held at zero outside message mode so every animation starts at frame 0.
  disp_prescaler #(.N(FRAME_DIV)) u_frame_div (
    .clk    (CLK),
    .rst_n  (RESET),
    .en_i   (digit_wrap & msg_act),
    .clr_i  (~msg_act),
    .cnt_o  (unused_frame_cnt),
    .wrap_o (frame_wrap)
  );

  always_comb begin
    digit_val = DIGIT0;
    case (dig_q)
      2'd1:    digit_val = DIGIT1;
      2'd2:    digit_val = DIGIT2;
      2'd3:    digit_val = DIGIT3;
      default: digit_val = DIGIT0;
    endcase

    // dig_q[1] separates the low pair (0,1) from the high pair (2,3).
    pane_msg = (msg_lo & ~dig_q[1]) | (msg_hi & dig_q[1]);

    // Invalid BCD passes straight through so the decoder shows its error glyph.
    count_d = pane_msg ? frm_q : digit_val;
    sa_d    = (scan_cnt < BLANK_END) ? SEL_NONE : sel_onehot(dig_q);
    dig_d   = scan_wrap ? dig_q + 2'd1 : dig_q;
    tick_d  = frame_wrap;

    frm_d = frm_q;
    if (!msg_act) begin
      frm_d = '0;
    end else if (frame_wrap) begin
      frm_d = (frm_q == FRAME_MAX) ? '0 : frm_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dig_q   <= '0;
      frm_q   <= '0;
      sa_q    <= SEL_NONE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      frm_q   <= frm_d;
      sa_q    <= sa_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign SA         = sa_q;
  assign COUNT      = count_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a short scan (4 cycles per
// digit, 1 blank cycle) and 2 frames per animation step. A reference model
// pushes the expected outputs for each clock edge into a scoreboard queue;
// they are popped and compared on the following falling edge. Scenario
// tasks add directed checks against hand-derived values.
module tb_disp_scan_ctrl;

  localparam int SCAN_DIV   = 4;
  localparam int BLANK      = 1;
  localparam int FRAME_DIV  = 2;
  localparam int FRAME_LAST = 6;

  logic       CLK;
  logic       RESET;
  logic [3:0] DIGIT0, DIGIT1, DIGIT2, DIGIT3;
  logic       TOP_CURRENT_STATE;
  logic [1:0] DIS_CURRENT_STATE;
  logic [3:0] COUNT;
  logic [3:0] SA;
  logic       FRAME_TICK;

  disp_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK),
    .FRAME_DIV    (FRAME_DIV),
    .FRAME_LAST   (FRAME_LAST)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DIGIT0            (DIGIT0),
    .DIGIT1            (DIGIT1),
    .DIGIT2            (DIGIT2),
    .DIGIT3            (DIGIT3),
    .TOP_CURRENT_STATE (TOP_CURRENT_STATE),
    .DIS_CURRENT_STATE (DIS_CURRENT_STATE),
    .COUNT             (COUNT),
    .SA                (SA),
    .FRAME_TICK        (FRAME_TICK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [3:0] sa;
    logic [3:0] count;
    logic       tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state.
  int m_scan, m_ptr, m_fscan, m_frm;

  task automatic model_reset();
    m_scan  = 0;
    m_ptr   = 0;
    m_fscan = 0;
    m_frm   = 0;
    sb_q.delete();
  endtask

  // One clock: model predicts at the rising edge, DUT is compared at the falling edge.
  task automatic run_cycle(output logic [3:0] sa_o, output logic [3:0] cnt_o, output logic tick_o);
    exp_t       e;
    exp_t       got;
    logic       lo, hi, act, dwrap;
    logic [3:0] dsel;
    @(posedge CLK);
    lo    = TOP_CURRENT_STATE & DIS_CURRENT_STATE[0];
    hi    = TOP_CURRENT_STATE & DIS_CURRENT_STATE[1] & ~lo;
    act   = lo | hi;
    dsel  = (m_ptr == 0) ? DIGIT0 : (m_ptr == 1) ? DIGIT1 : (m_ptr == 2) ? DIGIT2 : DIGIT3;
    e.sa    = (m_scan < BLANK) ? 4'b0000 : 4'(1 << m_ptr);
    e.count = ((lo && m_ptr < 2) || (hi && m_ptr >= 2)) ? 4'(m_frm) : dsel;
    e.tick  = act && (m_scan == SCAN_DIV - 1) && (m_ptr == 3) && (m_fscan == FRAME_DIV - 1);
    sb_q.push_back(e);
    dwrap = 1'b0;
    if (m_scan == SCAN_DIV - 1) begin
      m_scan = 0;
      if (m_ptr == 3) begin
        m_ptr = 0;
        dwrap = 1'b1;
      end else begin
        m_ptr++;
      end
    end else begin
      m_scan++;
    end
    if (!act) begin
      m_fscan = 0;
      m_frm   = 0;
    end else if (dwrap) begin
      if (m_fscan == FRAME_DIV - 1) begin
        m_fscan = 0;
        m_frm   = (m_frm == FRAME_LAST) ? 0 : m_frm + 1;
      end else begin
        m_fscan++;
      end
    end
    @(negedge CLK);
    got = sb_q.pop_front();
    n_checks++;
    if ({SA, COUNT, FRAME_TICK} !== {got.sa, got.count, got.tick})
      $display("FAIL scoreboard @%0t: got SA=%b COUNT=%h TICK=%b, want SA=%b COUNT=%h TICK=%b",
               $time, SA, COUNT, FRAME_TICK, got.sa, got.count, got.tick);
    else
      n_pass++;
    sa_o   = SA;
    cnt_o  = COUNT;
    tick_o = FRAME_TICK;
  endtask

  // Runs until SA shows sel; returns the COUNT seen alongside it.
  task automatic wait_sa(input logic [3:0] sel, input string tag, output logic [3:0] cnt);
    logic [3:0] s, c;
    logic       t;
    bit         found;
    found = 0;
    cnt   = 4'hx;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle(s, c, t);
      if (s === sel) begin
        found = 1;
        cnt   = c;
      end
    end
    n_checks++;
    if (!found) $display("FAIL %s: SA never reached %b within 40 cycles", tag, sel);
    else n_pass++;
  endtask

  // Runs until FRAME_TICK pulses; returns cycles consumed.
  task automatic wait_tick(input string tag, output int waited);
    logic [3:0] s, c;
    logic       t;
    bit         found;
    found  = 0;
    waited = 0;
    while (!found && waited < 80) begin
      run_cycle(s, c, t);
      waited++;
      if (t === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL %s: no FRAME_TICK within 80 cycles", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    DIGIT0 = 4'd4; DIGIT1 = 4'd3; DIGIT2 = 4'd2; DIGIT3 = 4'd1;
    TOP_CURRENT_STATE = 1'b0;
    DIS_CURRENT_STATE = 2'b00;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (SA !== 4'b0000) $display("FAIL reset_sa: got %b want 0000", SA); else n_pass++;
    n_checks++;
    if (COUNT !== 4'h0) $display("FAIL reset_count: got %h want 0", COUNT); else n_pass++;
    n_checks++;
    if (FRAME_TICK !== 1'b0) $display("FAIL reset_tick: got %b want 0", FRAME_TICK); else n_pass++;
    model_reset();
    RESET = 1'b1;
  endtask

  task automatic test_basic_scan();
    logic [3:0] sa_tab [16] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
                                4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                4'b0000, 4'b1000, 4'b1000, 4'b1000};
    logic [3:0] cnt_tab [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    logic [3:0] s, c;
    logic       t;
    for (int i = 0; i < 16; i++) begin
      run_cycle(s, c, t);
      n_checks++;
      if (s !== sa_tab[i]) $display("FAIL basic_sa[%0d]: got %b want %b", i, s, sa_tab[i]);
      else n_pass++;
      if (s !== 4'b0000) begin
        n_checks++;
        if (c !== cnt_tab[i / 4]) $display("FAIL basic_count[%0d]: got %h want %h", i, c, cnt_tab[i / 4]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_low_msg();
    logic [3:0] s, c;
    logic       t;
    int         waited;
    TOP_CURRENT_STATE = 1'b1;
    DIS_CURRENT_STATE = 2'b01;
    wait_sa(4'b0001, "low_d0_wait", c);
    n_checks++;
    if (c !== 4'd0) $display("FAIL low_d0_frame0: got %h want 0", c); else n_pass++;
    wait_sa(4'b0100, "low_d2_wait", c);
    n_checks++;
    if (c !== 4'd2) $display("FAIL low_d2_bcd: got %h want 2", c); else n_pass++;
    for (int k = 1; k <= 7; k++) begin
      wait_tick("low_tick", waited);
      if (k >= 2) begin
        n_checks++;
        if (waited != 31) $display("FAIL low_tick_period[%0d]: got %0d want 31 cycles", k, waited);
        else n_pass++;
      end
      run_cycle(s, c, t);
      n_checks++;
      if (c !== 4'(k % 7)) $display("FAIL low_frame_step[%0d]: got %h want %h", k, c, 4'(k % 7));
      else n_pass++;
    end
  endtask

  task automatic test_priority_pane();
    logic [3:0] c;
    int         waited;
    DIS_CURRENT_STATE = 2'b11;
    wait_sa(4'b0100, "prio_d2_wait", c);
    n_checks++;
    if (c !== 4'd2) $display("FAIL prio_d2_bcd: got %h want 2", c); else n_pass++;
    wait_sa(4'b0001, "prio_d0_wait", c);
    n_checks++;
    if (c !== 4'd0) $display("FAIL prio_d0_frame: got %h want 0", c); else n_pass++;
    for (int k = 0; k < 3; k++) wait_tick("prio_tick", waited);
    DIS_CURRENT_STATE = 2'b10;
    wait_sa(4'b0100, "pane_d2_wait", c);
    n_checks++;
    if (c !== 4'd3) $display("FAIL pane_d2_frame3: got %h want 3", c); else n_pass++;
    wait_sa(4'b0001, "pane_d0_wait", c);
    n_checks++;
    if (c !== 4'd4) $display("FAIL pane_d0_bcd: got %h want 4", c); else n_pass++;
    wait_tick("pane_tick", waited);
    wait_sa(4'b0100, "pane_d2_next_wait", c);
    n_checks++;
    if (c !== 4'd4) $display("FAIL pane_d2_frame4: got %h want 4", c); else n_pass++;
  endtask

  task automatic test_exit_reentry();
    logic [3:0] c;
    int         waited;
    wait_tick("exit_tick", waited);
    TOP_CURRENT_STATE = 1'b0;
    wait_sa(4'b1000, "exit_d3_wait", c);
    n_checks++;
    if (c !== 4'd1) $display("FAIL exit_d3_bcd: got %h want 1", c); else n_pass++;
    wait_sa(4'b0001, "exit_d0_wait", c);
    n_checks++;
    if (c !== 4'd4) $display("FAIL exit_d0_bcd: got %h want 4", c); else n_pass++;
    TOP_CURRENT_STATE = 1'b1;
    wait_sa(4'b0100, "reentry_d2_wait", c);
    n_checks++;
    if (c !== 4'd0) $display("FAIL reentry_frame0: got %h want 0", c); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [3:0] s, c;
    logic       t;
    int         waited;
    DIS_CURRENT_STATE = 2'b10;
    for (int k = 0; k < 4; k++) wait_tick("arst_tick", waited);
    wait_sa(4'b0100, "arst_d2_wait", c);
    n_checks++;
    if (c !== 4'd4) $display("FAIL arst_pre_frame4: got %h want 4", c); else n_pass++;
    #1 RESET = 1'b0;
    #1;
    n_checks++;
    if (SA !== 4'b0000) $display("FAIL arst_sa: got %b want 0000", SA); else n_pass++;
    n_checks++;
    if (COUNT !== 4'h0) $display("FAIL arst_count: got %h want 0", COUNT); else n_pass++;
    model_reset();
    #1 RESET = 1'b1;
    run_cycle(s, c, t);
    n_checks++;
    if (s !== 4'b0000 || c !== 4'd4)
      $display("FAIL arst_first_slot: got SA=%b COUNT=%h want SA=0000 COUNT=4", s, c);
    else n_pass++;
    run_cycle(s, c, t);
    n_checks++;
    if (s !== 4'b0001) $display("FAIL arst_d0_active: got %b want 0001", s); else n_pass++;
    wait_sa(4'b0100, "arst_post_d2_wait", c);
    n_checks++;
    if (c !== 4'd0) $display("FAIL arst_post_frame0: got %h want 0", c); else n_pass++;
  endtask

  task automatic test_invalid_bcd();
    logic [3:0] s, c;
    logic       t;
    TOP_CURRENT_STATE = 1'b0;
    DIGIT1 = 4'hC;
    for (int i = 0; i < 16; i++) begin
      run_cycle(s, c, t);
      if (s === 4'b0010) begin
        n_checks++;
        if (c !== 4'hC) $display("FAIL invalid_bcd: got %h want C", c); else n_pass++;
      end
    end
    // Mid-slot digit change shows up on the very next cycle.
    wait_sa(4'b0001, "midslot_wait", c);
    DIGIT0 = 4'd9;
    run_cycle(s, c, t);
    n_checks++;
    if (s !== 4'b0001 || c !== 4'd9)
      $display("FAIL midslot_change: got SA=%b COUNT=%h want SA=0001 COUNT=9", s, c);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_low_msg();
    test_priority_pane();
    test_exit_reentry();
    test_async_reset();
    test_invalid_bcd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
